// File: rtl/idu_pipe.sv
// Registered RV32I/E decode stage: decodes an instruction, reads the GPR file and tracks busy destinations.
// Latency 1 cycle from in_valid&&in_ready to out_valid. Optional macro IDU_WB_BYPASS_EN forwards writeback data to operands.
// Backpressure: in_ready drops while the held bundle is not taken, on a RAW hazard, or during flush.
module idu_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [3:0]      out_itype,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_use,
  output logic            out_invld,
  output logic            out_ebreak,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);

  localparam int         RA_W = $clog2(NREGS);
  localparam logic [5:0] NR   = 6'(NREGS);
`ifdef IDU_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [3:0] {
    IT_INVLD  = 4'd0,  IT_R     = 4'd1,  IT_ICOMP = 4'd2, IT_ISHIFT = 4'd3,
    IT_LUI    = 4'd4,  IT_AUIPC = 4'd5,  IT_JAL   = 4'd6, IT_JALR   = 4'd7,
    IT_BR     = 4'd8,  IT_LD    = 4'd9,  IT_ST    = 4'd10, IT_ECALL = 4'd11,
    IT_EBREAK = 4'd12
  } itype_t;

  // use vector bit positions: {rd, pc, imm, rs2, rs1}
  localparam logic [4:0] U_RS1 = 5'b00001;
  localparam logic [4:0] U_RS2 = 5'b00010;
  localparam logic [4:0] U_IMM = 5'b00100;
  localparam logic [4:0] U_PC  = 5'b01000;
  localparam logic [4:0] U_RD  = 5'b10000;

  logic [XLEN-1:0] gpr [NREGS];
  logic [NREGS-1:0] busy, busy_nxt;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  assign opc = in_instr[6:0];
  assign rd  = in_instr[11:7];
  assign f3  = in_instr[14:12];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign f7  = in_instr[31:25];

  itype_t      dec_itype;
  logic [3:0]  dec_alu;
  logic [4:0]  dec_use;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rd;
  logic        bad_idx;

  // Instruction decode: type, ALU op, operand usage and immediate.
  always_comb begin
    dec_itype = IT_INVLD;
    dec_alu   = 4'd0;
    dec_use   = 5'b0;
    dec_imm   = 32'd0;
    bad_idx   = 1'b0;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          dec_itype = IT_R;
          dec_alu   = {in_instr[30], f3};
          dec_use   = U_RD | U_RS2 | U_RS1;
        end
      end
      7'b0010011: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          if (f7 == 7'h00 || (f3 == 3'b101 && f7 == 7'h20)) begin
            dec_itype = IT_ISHIFT;
            dec_alu   = {in_instr[30], f3};
            dec_use   = U_RD | U_IMM | U_RS1;
            dec_imm   = {27'd0, in_instr[24:20]};
          end
        end else begin
          dec_itype = IT_ICOMP;
          dec_alu   = {1'b0, f3};
          dec_use   = U_RD | U_IMM | U_RS1;
          dec_imm   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0110111: begin
        dec_itype = IT_LUI;
        dec_use   = U_RD | U_IMM;
        dec_imm   = {in_instr[31:12], 12'd0};
      end
      7'b0010111: begin
        dec_itype = IT_AUIPC;
        dec_use   = U_RD | U_PC | U_IMM;
        dec_imm   = {in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_itype = IT_JAL;
        dec_use   = U_RD | U_PC | U_IMM;
        dec_imm   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
      end
      7'b1100111: begin
        dec_itype = IT_JALR;
        dec_use   = U_RD | U_PC | U_IMM | U_RS1;
        dec_imm   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b1100011: begin
        dec_itype = IT_BR;
        dec_alu   = {1'b0, f3};
        dec_use   = U_PC | U_IMM | U_RS2 | U_RS1;
        dec_imm   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
      end
      7'b0000011: begin
        dec_itype = IT_LD;
        dec_alu   = {1'b0, f3};
        dec_use   = U_RD | U_IMM | U_RS1;
        dec_imm   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_itype = IT_ST;
        dec_alu   = {1'b0, f3};
        dec_use   = U_IMM | U_RS2 | U_RS1;
        dec_imm   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1110011: begin
        if (in_instr == 32'h0000_0073) dec_itype = IT_ECALL;
        else if (in_instr == 32'h0010_0073) dec_itype = IT_EBREAK;
      end
      default: dec_itype = IT_INVLD;
    endcase
    // RV32E: any referenced register beyond the implemented file makes the op illegal
    bad_idx = (dec_use[0] && {1'b0, rs1} >= NR) || (dec_use[1] && {1'b0, rs2} >= NR) ||
              (dec_use[4] && {1'b0, rd} >= NR);
    if (bad_idx) begin
      dec_itype = IT_INVLD;
      dec_alu   = 4'd0;
      dec_use   = 5'b0;
      dec_imm   = 32'd0;
    end
    dec_rd = dec_use[4] ? rd : 5'd0;
  end

  logic rs1_ok, rs2_ok, wb_ok, ord_ok;
  logic byp1, byp2;
  assign rs1_ok = {1'b0, rs1} < NR;
  assign rs2_ok = {1'b0, rs2} < NR;
  assign wb_ok  = {1'b0, wb_rd} < NR && wb_rd != 5'd0;
  assign ord_ok = {1'b0, out_rd} < NR && out_rd != 5'd0;
  assign byp1   = BYPASS && wb_en && wb_rd == rs1;
  assign byp2   = BYPASS && wb_en && wb_rd == rs2;

  logic [XLEN-1:0] rs1_val, rs2_val;

  // Operand read; x0 is hardwired to zero and optionally forwarded from writeback.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && rs1_ok) rs1_val = byp1 ? wb_data : gpr[rs1[RA_W-1:0]];
    if (rs2 != 5'd0 && rs2_ok) rs2_val = byp2 ? wb_data : gpr[rs2[RA_W-1:0]];
  end

  logic haz1, haz2, hazard, accept, issue;

  // RAW hazard: source busy in the scoreboard, or being produced by the bundle still held at the output.
  always_comb begin
    haz1 = dec_use[0] && rs1 != 5'd0 &&
           ((rs1_ok && busy[rs1[RA_W-1:0]] && !byp1) ||
            (out_valid && out_use[4] && out_rd == rs1));
    haz2 = dec_use[1] && rs2 != 5'd0 &&
           ((rs2_ok && busy[rs2[RA_W-1:0]] && !byp2) ||
            (out_valid && out_use[4] && out_rd == rs2));
  end

  assign hazard   = haz1 || haz2;
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  // A flushed bundle never counts as issued, so it cannot mark its destination busy.
  assign issue    = out_valid && out_ready && !flush;

  // Output bundle register: load on accept, drop on handshake or flush, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rd      <= '0;
      out_itype   <= '0;
      out_alu_op  <= '0;
      out_use     <= '0;
      out_invld   <= 1'b0;
      out_ebreak  <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_rs1_val <= rs1_val;
      out_rs2_val <= rs2_val;
      out_imm     <= XLEN'($signed(dec_imm));
      out_pc      <= in_pc;
      out_rd      <= dec_rd;
      out_itype   <= dec_itype;
      out_alu_op  <= dec_alu;
      out_use     <= dec_use;
      out_invld   <= (dec_itype == IT_INVLD);
      out_ebreak  <= (dec_itype == IT_EBREAK);
    end else if ((out_valid && out_ready) || flush) begin
      out_valid  <= 1'b0;
      out_ebreak <= 1'b0;
    end
  end

  // Scoreboard next state: writeback clears, issue sets (set wins), x0 never busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_en && wb_ok) busy_nxt[wb_rd[RA_W-1:0]] = 1'b0;
    if (issue && out_use[4] && ord_ok) busy_nxt[out_rd[RA_W-1:0]] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // GPR file write port; writes to x0 and unimplemented indices are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else if (wb_en && wb_ok) begin
      gpr[wb_rd[RA_W-1:0]] <= wb_data;
    end
  end

endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: decode table plus hazard, stall/flush, RV32E and x0 sequences.
// A 32-register and a 16-register instance share all inputs.
// Register contents are tracked in a shadow array filled by the bench's own writebacks.
module tb_idu_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, wb_en, flush;
  logic [31:0] in_instr, in_pc, wb_data;
  logic [4:0]  wb_rd;

  logic        in_ready, out_valid, out_invld, out_ebreak;
  logic [31:0] out_rs1_val, out_rs2_val, out_imm, out_pc;
  logic [4:0]  out_rd, out_use;
  logic [3:0]  out_itype, out_alu_op;

  logic        e_in_ready, e_out_valid, e_out_invld, e_out_ebreak;
  logic [31:0] e_rs1_val, e_rs2_val, e_imm, e_pc;
  logic [4:0]  e_rd, e_use;
  logic [3:0]  e_itype, e_alu_op;

  always #5 clk = ~clk;

  idu_pipe #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_pc(out_pc), .out_rd(out_rd), .out_itype(out_itype), .out_alu_op(out_alu_op),
    .out_use(out_use), .out_invld(out_invld), .out_ebreak(out_ebreak),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
  );

  idu_pipe #(.XLEN(32), .NREGS(16)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(e_out_valid), .out_ready(out_ready),
    .out_rs1_val(e_rs1_val), .out_rs2_val(e_rs2_val), .out_imm(e_imm),
    .out_pc(e_pc), .out_rd(e_rd), .out_itype(e_itype), .out_alu_op(e_alu_op),
    .out_use(e_use), .out_invld(e_out_invld), .out_ebreak(e_out_ebreak),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  itype;
    logic [31:0] imm;
    logic [4:0]  uses;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        invld;
    logic        ebrk;
  } vec_t;

  vec_t        vecs [18];
  logic [31:0] regs [32];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; wb_en = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0000_0013;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
  endtask

  task automatic wb_pulse(input logic [4:0] r, input logic [31:0] d);
    @(negedge clk);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0000_0013; in_pc = 32'd0;
    out_ready = 1'b1; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0;

    //                 instr         itype  imm            uses      rd     alu   inv   ebk
    vecs[0]  = '{32'hFFB00093, 4'd2,  32'hFFFFFFFB, 5'b10101, 5'd1, 4'd0,  1'b0, 1'b0};
    vecs[1]  = '{32'h00108133, 4'd1,  32'h00000000, 5'b10011, 5'd2, 4'd0,  1'b0, 1'b0};
    vecs[2]  = '{32'h401101B3, 4'd1,  32'h00000000, 5'b10011, 5'd3, 4'd8,  1'b0, 1'b0};
    vecs[3]  = '{32'h4031D213, 4'd3,  32'h00000003, 5'b10101, 5'd4, 4'd13, 1'b0, 1'b0};
    vecs[4]  = '{32'h123452B7, 4'd4,  32'h12345000, 5'b10100, 5'd5, 4'd0,  1'b0, 1'b0};
    vecs[5]  = '{32'hFFFFF317, 4'd5,  32'hFFFFF000, 5'b11100, 5'd6, 4'd0,  1'b0, 1'b0};
    vecs[6]  = '{32'hFFDFF0EF, 4'd6,  32'hFFFFFFFC, 5'b11100, 5'd1, 4'd0,  1'b0, 1'b0};
    vecs[7]  = '{32'h00008067, 4'd7,  32'h00000000, 5'b11101, 5'd0, 4'd0,  1'b0, 1'b0};
    vecs[8]  = '{32'h00208463, 4'd8,  32'h00000008, 5'b01111, 5'd0, 4'd0,  1'b0, 1'b0};
    vecs[9]  = '{32'hFE009CE3, 4'd8,  32'hFFFFFFF8, 5'b01111, 5'd0, 4'd1,  1'b0, 1'b0};
    vecs[10] = '{32'hFF012383, 4'd9,  32'hFFFFFFF0, 5'b10101, 5'd7, 4'd2,  1'b0, 1'b0};
    vecs[11] = '{32'h00112A23, 4'd10, 32'h00000014, 5'b00111, 5'd0, 4'd2,  1'b0, 1'b0};
    vecs[12] = '{32'h7FF3F413, 4'd2,  32'h000007FF, 5'b10101, 5'd8, 4'd7,  1'b0, 1'b0};
    vecs[13] = '{32'h00000073, 4'd11, 32'h00000000, 5'b00000, 5'd0, 4'd0,  1'b0, 1'b0};
    vecs[14] = '{32'h00100073, 4'd12, 32'h00000000, 5'b00000, 5'd0, 4'd0,  1'b0, 1'b1};
    vecs[15] = '{32'hFFFFFFFF, 4'd0,  32'h00000000, 5'b00000, 5'd0, 4'd0,  1'b1, 1'b0};
    vecs[16] = '{32'h02000033, 4'd0,  32'h00000000, 5'b00000, 5'd0, 4'd0,  1'b1, 1'b0};
    vecs[17] = '{32'h30529073, 4'd0,  32'h00000000, 5'b00000, 5'd0, 4'd0,  1'b1, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_itype",     {28'd0, out_itype}, 32'd0);
    chk("rst_imm",       out_imm, 32'd0);
    chk("rst_use",       {27'd0, out_use}, 32'd0);
    chk("rst_ebreak",    {31'd0, out_ebreak}, 32'd0);

    // Decode table: issue, check bundle, then write back the destination to clear busy
    for (int i = 0; i < 18; i++) begin
      logic [31:0] pc, wv;
      logic [4:0]  s1, s2;
      pc = 32'h0000_1000 + 32'(i) * 4;
      wv = 32'hA000_0000 + 32'(i) * 32'h111;
      s1 = vecs[i].instr[19:15];
      s2 = vecs[i].instr[24:20];
      @(negedge clk);
      wb_en = 1'b0; in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = pc;
      #1 chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_itype", i), {28'd0, out_itype}, {28'd0, vecs[i].itype});
      chk($sformatf("v%0d_imm", i),   out_imm, vecs[i].imm);
      chk($sformatf("v%0d_use", i),   {27'd0, out_use}, {27'd0, vecs[i].uses});
      chk($sformatf("v%0d_rd", i),    {27'd0, out_rd}, {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_alu", i),   {28'd0, out_alu_op}, {28'd0, vecs[i].alu});
      chk($sformatf("v%0d_invld", i), {31'd0, out_invld}, {31'd0, vecs[i].invld});
      chk($sformatf("v%0d_ebreak", i), {31'd0, out_ebreak}, {31'd0, vecs[i].ebrk});
      chk($sformatf("v%0d_pc", i),    out_pc, pc);
      if (vecs[i].uses[0]) chk($sformatf("v%0d_rs1", i), out_rs1_val, regs[s1]);
      if (vecs[i].uses[1]) chk($sformatf("v%0d_rs2", i), out_rs2_val, regs[s2]);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_drained", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d_ebreak_drop", i), {31'd0, out_ebreak}, 32'd0);
      if (vecs[i].uses[4] && vecs[i].rd != 5'd0) begin
        wb_en = 1'b1; wb_rd = vecs[i].rd; wb_data = wv; regs[vecs[i].rd] = wv;
      end
    end
    @(negedge clk);
    wb_en = 1'b0;

    // Reset clears the register file: every x1..x31 reads back zero
    do_reset();
    for (int k = 1; k < 32; k++) begin
      logic [31:0] ins;
      ins = (32'(k) << 20) | (32'(k) << 15) | 32'h33;
      @(negedge clk);
      in_valid = 1'b1; in_instr = ins;
      #1 chk($sformatf("clr_x%0d_rdy", k), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk($sformatf("clr_x%0d_val", k), out_rs1_val | out_rs2_val, 32'd0);
    end

    // RAW hazard: addi x1 then add x2,x1,x1 back to back, released by writeback of 7
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hFFB00093;
    #1 chk("raw_first_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_instr = 32'h00108133;
    #1 chk("raw_outreg_stall", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 chk($sformatf("raw_busy_stall%0d", c), {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
`ifdef IDU_WB_BYPASS_EN
    #1 chk("raw_wb_cycle_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    wb_en = 1'b0; in_valid = 1'b0;
`else
    #1 chk("raw_wb_cycle_rdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    wb_en = 1'b0;
    #1 chk("raw_after_wb_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
`endif
    #1;
    chk("raw_add_valid", {31'd0, out_valid}, 32'd1);
    chk("raw_add_itype", {28'd0, out_itype}, 32'd1);
    chk("raw_add_rs1",   out_rs1_val, 32'd7);
    chk("raw_add_rs2",   out_rs2_val, 32'd7);
    wb_pulse(5'd2, 32'd14);

    // Stall then flush: busy[5] from an issued op must survive; squashed x3 must not become busy
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00900293;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00100193;
    #1 chk("hold_accept_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_imm", c),   out_imm, 32'd1);
      chk($sformatf("hold%0d_rd", c),    {27'd0, out_rd}, 32'd3);
      chk($sformatf("hold%0d_rdy", c),   {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    flush = 1'b1;
    #1 chk("flush_rdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1; in_instr = 32'h00028333;
    #1;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_busy_kept", {31'd0, in_ready}, 32'd0);
    in_instr = 32'h00018233;
    #1 chk("flush_no_busy", {31'd0, in_ready}, 32'd1);
    wb_pulse(5'd5, 32'd9);

    // RV32E: x17 is out of range and decodes illegal only in the 16-register build
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h002088B3;
    #1 chk("e_rdy", {31'd0, e_in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("e_valid", {31'd0, e_out_valid}, 32'd1);
    chk("e_invld", {31'd0, e_out_invld}, 32'd1);
    chk("e_use",   {27'd0, e_use}, 32'd0);
    chk("e_itype", {28'd0, e_itype}, 32'd0);
    chk("i_invld", {31'd0, out_invld}, 32'd0);
    chk("i_rd",    {27'd0, out_rd}, 32'd17);
    wb_pulse(5'd17, 32'd1);

    // x0: a writeback to x0 is neither stored nor forwarded
    @(negedge clk);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'd5; in_valid = 1'b1; in_instr = 32'h00000033;
    #1 chk("x0_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    wb_en = 1'b0;
    #1;
    chk("x0_same_cycle", out_rs1_val, 32'd0);
    chk("x0_e_same_cycle", e_rs1_val, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("x0_later", out_rs1_val | out_rs2_val, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
